fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue_if.sv | 62 ++++++
 rtl/fetch_decode_queue.sv | 108 ++++++++++
 tb/tb_fetch_decode_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue types and the handshake interface between fetch, queue and decode.
// fdq_pkg holds the exception code and branch-prediction sideband carried with each entry.
// Interface modports:
//   master - the fetch/decode side.
//   slave  - the queue itself.
package fdq_pkg;

  typedef enum logic [3:0] {
    NO_EXCEPTION         = 4'd0,
    INST_ADDR_MISALIGNED = 4'd1,
    INST_ACCESS_FAULT    = 4'd2,
    ILLEGAL_INST         = 4'd3,
    BREAKPOINT           = 4'd4,
    INST_PAGE_FAULT      = 4'd5
  } exc_type_e;

  typedef struct packed {
    logic        taken;
    logic [1:0]  bht_state;
    logic [31:0] target;
  } predict_info_t;

endpackage

interface fetch_decode_queue_if #(
  parameter int XLEN = 32
);
  import fdq_pkg::*;

  // enqueue channel (fetch -> queue)
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [XLEN-1:0] enq_pc_i;
  logic [XLEN-1:0] enq_inst_i;
  logic            enq_is_comp_i;
  exc_type_e       enq_exc_i;
  predict_info_t   enq_spec_i;

  // dequeue channel (queue -> decode)
  logic            deq_valid_o;
  logic            deq_ready_i;
  logic [XLEN-1:0] deq_pc_o;
  logic [XLEN-1:0] deq_inst_o;
  logic            deq_is_comp_o;
  exc_type_e       deq_exc_o;
  predict_info_t   deq_spec_o;

  modport master (
    output enq_valid_i, enq_pc_i, enq_inst_i, enq_is_comp_i, enq_exc_i, enq_spec_i,
    output deq_ready_i,
    input  enq_ready_o,
    input  deq_valid_o, deq_pc_o, deq_inst_o, deq_is_comp_o, deq_exc_o, deq_spec_o
  );

  modport slave (
    input  enq_valid_i, enq_pc_i, enq_inst_i, enq_is_comp_i, enq_exc_i, enq_spec_i,
    input  deq_ready_i,
    output enq_ready_o,
    output deq_valid_o, deq_pc_o, deq_inst_o, deq_is_comp_o, deq_exc_o, deq_spec_o
  );

endinterface

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of DEPTH entries (power of two, >= 2).
// Each entry carries PC, expanded instruction, compressed flag, exception code and
// prediction sideband. Flush (redirect/trap) empties the queue on the next edge.
// Optional macro FDQ_BYPASS_EN: when empty, the offered entry passes straight through to
// decode combinationally and, if consumed, is never written into storage.
module fetch_decode_queue
  import fdq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  fetch_decode_queue_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            is_comp;
    exc_type_e       exc;
    predict_info_t   spec;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  entry_t          enq_entry;
  entry_t          head_entry;
  entry_t          out_entry;
  logic            enq_ready;
  logic            deq_valid;
  logic            enq_fire;
  logic            deq_fire;
  logic            bypass_take;
  logic            push;
  logic            pop;

  // Handshake decode: readiness, head selection, optional empty-queue bypass.
  always_comb begin
    enq_entry   = '{pc: bus.enq_pc_i, inst: bus.enq_inst_i, is_comp: bus.enq_is_comp_i,
                    exc: bus.enq_exc_i, spec: bus.enq_spec_i};
    head_entry  = mem[rd_ptr_reg];
    // A full queue refuses offers even when decode drains this cycle.
    enq_ready   = (count_reg < CW'(DEPTH)) && !flush_i && !rst_i;
    deq_valid   = (count_reg != '0) && !flush_i;
    out_entry   = head_entry;
    bypass_take = 1'b0;
`ifdef FDQ_BYPASS_EN
    if ((count_reg == '0) && !flush_i) begin
      deq_valid   = bus.enq_valid_i;
      out_entry   = enq_entry;
      bypass_take = bus.enq_valid_i && bus.deq_ready_i && enq_ready;
    end
`endif
    enq_fire = bus.enq_valid_i && enq_ready;
    deq_fire = deq_valid && bus.deq_ready_i;
    // A bypassed entry touches neither storage nor the counters.
    push     = enq_fire && !bypass_take;
    pop      = deq_fire && !bypass_take;
  end

  // Drive decode-side outputs; data is forced to zero whenever nothing is presented.
  always_comb begin
    bus.enq_ready_o   = enq_ready;
    bus.deq_valid_o   = deq_valid;
    bus.deq_pc_o      = deq_valid ? out_entry.pc      : '0;
    bus.deq_inst_o    = deq_valid ? out_entry.inst    : '0;
    bus.deq_is_comp_o = deq_valid ? out_entry.is_comp : 1'b0;
    bus.deq_exc_o     = deq_valid ? out_entry.exc     : NO_EXCEPTION;
    bus.deq_spec_o    = deq_valid ? out_entry.spec    : '0;
  end

  // Entry storage; contents are left uninitialised since outputs are gated by deq_valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= enq_entry;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // Pointers are PW bits wide, so incrementing past DEPTH-1 wraps to 0.
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count_o = count_reg;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed testbench for fetch_decode_queue (DEPTH=4, XLEN=32) with a scoreboard queue.
// Honours FDQ_BYPASS_EN so the same bench checks both builds.
module tb_fetch_decode_queue;
  import fdq_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic          comp;
    exc_type_e     exc;
    predict_info_t spec;
  } tb_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int fails  = 0;

  tb_entry_t sb[$];

  fetch_decode_queue_if #(.XLEN(XLEN)) bus ();

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus),
    .count_o (count)
  );

  always #5 clk = ~clk;

  function automatic tb_entry_t make_entry(input logic [31:0] pc);
    tb_entry_t e;
    e.pc   = pc;
    e.inst = (pc ^ 32'hA5A5_0F0F) + 32'h13;
    e.comp = pc[2];
    case (pc[3:2])
      2'd1:    e.exc = ILLEGAL_INST;
      2'd3:    e.exc = INST_PAGE_FAULT;
      default: e.exc = NO_EXCEPTION;
    endcase
    e.spec.taken     = pc[3];
    e.spec.bht_state = pc[5:4];
    e.spec.target    = pc + 32'h40;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check outputs, then update the model at the edge.
  task automatic step(input logic ev, input logic [31:0] pc, input logic dr,
                      input logic fl, input logic rs);
    tb_entry_t offer, exp_e, zero_e;
    logic exp_ready, exp_valid, byp, efire, dfire;
    int   n;
    @(negedge clk);
    offer             = make_entry(pc);
    bus.enq_valid_i   = ev;
    bus.enq_pc_i      = offer.pc;
    bus.enq_inst_i    = offer.inst;
    bus.enq_is_comp_i = offer.comp;
    bus.enq_exc_i     = offer.exc;
    bus.enq_spec_i    = offer.spec;
    bus.deq_ready_i   = dr;
    flush             = fl;
    rst               = rs;
    #1;
    n         = sb.size();
    exp_ready = (n < DEPTH) && !fl && !rs;
`ifdef FDQ_BYPASS_EN
    byp = (n == 0) && !fl;
`else
    byp = 1'b0;
`endif
    zero_e     = '0;
    zero_e.exc = NO_EXCEPTION;
    exp_valid  = byp ? ev : ((n != 0) && !fl);
    exp_e      = zero_e;
    if (exp_valid) exp_e = byp ? offer : sb[0];

    check("count",     64'(count),             64'(n));
    check("enq_ready", 64'(bus.enq_ready_o),   64'(exp_ready));
    check("deq_valid", 64'(bus.deq_valid_o),   64'(exp_valid));
    check("deq_pc",    64'(bus.deq_pc_o),      64'(exp_e.pc));
    check("deq_inst",  64'(bus.deq_inst_o),    64'(exp_e.inst));
    check("deq_comp",  64'(bus.deq_is_comp_o), 64'(exp_e.comp));
    check("deq_exc",   64'(bus.deq_exc_o),     64'(exp_e.exc));
    check("deq_spec",  64'(bus.deq_spec_o),    64'(exp_e.spec));

    efire = ev && exp_ready;
    dfire = dr && exp_valid;
    if (efire) $display("enq pc=%h count=%0d", offer.pc, n);
    if (dfire) $display("deq pc=%h exc=%0d", exp_e.pc, exp_e.exc);
    if (fl)    $display("flush count=%0d", n);
    if (rs)    $display("reset count=%0d", n);
    @(posedge clk);
    if (rs || fl) begin
      sb.delete();
    end else if (!(byp && efire && dfire)) begin
      if (dfire) void'(sb.pop_front());
      if (efire) sb.push_back(offer);
    end
  endtask

  initial begin
    bus.enq_valid_i   = 1'b0;
    bus.enq_pc_i      = '0;
    bus.enq_inst_i    = '0;
    bus.enq_is_comp_i = 1'b0;
    bus.enq_exc_i     = NO_EXCEPTION;
    bus.enq_spec_i    = '0;
    bus.deq_ready_i   = 1'b0;
    flush             = 1'b0;
    rst               = 1'b1;
    repeat (2) @(posedge clk);

    // reset held, then released: ready high, nothing presented
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // fill to DEPTH with decode stalled
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h8000_0000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    // full with simultaneous dequeue: offer refused, count drops by one
    step(1'b1, 32'h8000_0100, 1'b1, 1'b0, 1'b0);
    // drain remaining entries in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // wrap: ten streamed enq/deq pairs
    for (int i = 0; i < 10; i++) step(1'b1, 32'h8000_1000 + 32'(4*i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // flush with three queued and a concurrent offer
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8000_2000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEE0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_3004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // empty queue, offer with decode ready (bypass or one-cycle latency)
    step(1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // reset mid-operation with two queued
    step(1'b1, 32'h8000_4008, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_400C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_5004, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
